rle_pixel_gen: RTL and testbench



---
 rtl/rle_pixel_gen.sv | 141 ++++++++++++++
 tb/tb_rle_pixel_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rle_pixel_gen.sv
// Run-length pixel generator: expands {length, colour} run tokens
// into one registered colour per pixel clock, black during blanking.
//
// Ports:
//   clk        pixel clock
//   reset      synchronous, active-high reset
//   blank      1 = non-displayed pixel this cycle (from timing stage)
//   next_frame 1-cycle end-of-frame pulse; flushes both run slots
//   run_data   token {length, colour}, length in the MSBs
//   run_valid  token available
//   run_ready  token accepted when run_valid && run_ready
//   rgb        registered pixel colour (1-cycle latency)
//   underflow  sticky: an active pixel found no run loaded
module rle_pixel_gen #(
  parameter int LEN_W    = 10,
  parameter int COLOUR_W = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      blank,
  input  logic                      next_frame,
  input  logic [LEN_W+COLOUR_W-1:0] run_data,
  input  logic                      run_valid,
  output logic                      run_ready,
  output logic [COLOUR_W-1:0]       rgb,
  output logic                      underflow
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  // current run slot
  logic                cur_valid_q, cur_valid_d;
  logic [COLOUR_W-1:0] cur_colour_q, cur_colour_d;
  logic [LEN_W-1:0]    cur_rem_q, cur_rem_d;

  // next run slot
  logic                nxt_valid_q, nxt_valid_d;
  logic [COLOUR_W-1:0] nxt_colour_q, nxt_colour_d;
  logic [LEN_W-1:0]    nxt_len_q, nxt_len_d;

  // outputs
  logic [COLOUR_W-1:0] rgb_q, rgb_d;
  logic                uf_q, uf_d;

  // token fields
  logic [LEN_W-1:0]    tok_len;
  logic [COLOUR_W-1:0] tok_colour;

  // per-cycle control
  logic consume;
  logic cur_last;
  logic cur_done;
  logic advance;
  logic xfer;

  assign tok_len    = run_data[LEN_W+COLOUR_W-1:COLOUR_W];
  assign tok_colour = run_data[COLOUR_W-1:0];

  assign consume  = !blank && cur_valid_q;
  assign cur_last = (cur_rem_q == '0);
  assign cur_done = consume && cur_last;

  // An empty cur slot pulls from nxt even while blanked, so the
  // first run of a line is already loaded when display starts.
  assign advance = nxt_valid_q && (!cur_valid_q || cur_done);

  // Combinational from blank: nxt frees up in the same cycle its
  // run moves into cur, which keeps 1-pixel runs bubble-free.
  assign run_ready = !next_frame && (!nxt_valid_q || advance);
  assign xfer      = run_valid && run_ready;

  always_comb begin
    cur_valid_d  = cur_valid_q;
    cur_colour_d = cur_colour_q;
    cur_rem_d    = cur_rem_q;
    nxt_valid_d  = nxt_valid_q;
    nxt_colour_d = nxt_colour_q;
    nxt_len_d    = nxt_len_q;
    rgb_d        = '0;
    uf_d         = uf_q;

    if (next_frame) begin
      // Upstream restarts its stream on this pulse: drop both slots.
      cur_valid_d = 1'b0;
      nxt_valid_d = 1'b0;
      uf_d        = 1'b0;
    end else begin
      if (consume) begin
        rgb_d = cur_colour_q;
      end
      if (!blank && !cur_valid_q) begin
        uf_d = 1'b1;
      end

      if (advance) begin
        cur_valid_d  = 1'b1;
        cur_rem_d    = nxt_len_q;
        cur_colour_d = nxt_colour_q;
      end else if (consume && !cur_last) begin
        cur_rem_d = cur_rem_q - LEN_ONE;
      end else if (cur_done) begin
        cur_valid_d = 1'b0;
      end

      // A refill in the advance cycle keeps nxt occupied.
      if (xfer) begin
        nxt_valid_d  = 1'b1;
        nxt_len_d    = tok_len;
        nxt_colour_d = tok_colour;
      end else if (advance) begin
        nxt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_valid_q  <= 1'b0;
      cur_colour_q <= '0;
      cur_rem_q    <= '0;
      nxt_valid_q  <= 1'b0;
      nxt_colour_q <= '0;
      nxt_len_q    <= '0;
      rgb_q        <= '0;
      uf_q         <= 1'b0;
    end else begin
      cur_valid_q  <= cur_valid_d;
      cur_colour_q <= cur_colour_d;
      cur_rem_q    <= cur_rem_d;
      nxt_valid_q  <= nxt_valid_d;
      nxt_colour_q <= nxt_colour_d;
      nxt_len_q    <= nxt_len_d;
      rgb_q        <= rgb_d;
      uf_q         <= uf_d;
    end
  end

  assign rgb       = rgb_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_rle_pixel_gen.sv
// Self-checking bench for rle_pixel_gen: directed table, corner
// sequences and random traffic against a run-queue reference model.
module tb_rle_pixel_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        blank;
  logic        next_frame;
  logic [15:0] run_data;
  logic        run_valid;
  logic        run_ready;
  logic [5:0]  rgb;
  logic        underflow;

  rle_pixel_gen #(.LEN_W(10), .COLOUR_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .blank      (blank),
    .next_frame (next_frame),
    .run_data   (run_data),
    .run_valid  (run_valid),
    .run_ready  (run_ready),
    .rgb        (rgb),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: queue of accepted runs, pixels still to show, and a flag
  // telling whether the head run is the one on screen yet.
  typedef struct {
    int         left;
    logic [5:0] col;
  } run_t;

  run_t       q[$];
  logic       hl = 1'b0;
  logic       m_uf = 1'b0;
  logic [5:0] e_rgb = '0;
  logic       rdy_s;

  typedef struct {
    logic        r;
    logic        b;
    logic        n;
    logic        v;
    logic [15:0] d;
    logic        ck_rdy;
    logic        rdy;
    logic [5:0]  rgb;
    logic        uf;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp,
               $time);
    end
  endtask

  function automatic logic [15:0] tok(input int len,
                                      input logic [5:0] c);
    logic [9:0] l;
    l = 10'(len);
    return {l, c};
  endfunction

  task automatic cyc(input logic r, input logic b, input logic n,
                     input logic v, input logic [15:0] d);
    logic live, nocc, disp, fin, adv, rdy_m;
    run_t h;
    reset      = r;
    blank      = b;
    next_frame = n;
    run_valid  = v;
    run_data   = d;
    #2;
    live  = (q.size() > 0) && hl;
    nocc  = (q.size() == 2) || (q.size() == 1 && !hl);
    disp  = !b && live;
    fin   = disp && (q[0].left == 1);
    adv   = nocc && (!live || fin);
    rdy_m = !n && (!nocc || adv);
    rdy_s = run_ready;
    if (!r) chk("run_ready", {31'd0, run_ready}, {31'd0, rdy_m});
    if (r || n) begin
      q.delete();
      hl    = 1'b0;
      m_uf  = 1'b0;
      e_rgb = '0;
    end else begin
      e_rgb = disp ? q[0].col : 6'd0;
      if (!b && !live) m_uf = 1'b1;
      if (disp) begin
        h = q[0];
        h.left--;
        q[0] = h;
        if (h.left == 0) begin
          void'(q.pop_front());
          hl = 1'b0;
        end
      end
      if (!hl && q.size() > 0) hl = 1'b1;
      if (v && rdy_m) begin
        h.left = int'(d[15:6]) + 1;
        h.col  = d[5:0];
        q.push_back(h);
      end
    end
    @(posedge clk);
    #1;
    chk("rgb", {26'd0, rgb}, {26'd0, e_rgb});
    chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
  endtask

  initial begin
    reset = 1'b1; blank = 1'b1; next_frame = 1'b0;
    run_valid = 1'b0; run_data = '0;

    //          r  b  n  v  data          ck rdy rgb   uf
    tbl[0]  = '{1, 0, 0, 1, 16'h00F0, 0, 0, 6'h00, 0};
    tbl[1]  = '{1, 0, 0, 1, 16'h00F0, 0, 0, 6'h00, 0};
    tbl[2]  = '{0, 1, 0, 1, 16'h00F0, 1, 1, 6'h00, 0};
    tbl[3]  = '{0, 1, 0, 1, 16'h000C, 1, 1, 6'h00, 0};
    tbl[4]  = '{0, 0, 0, 0, 16'h0000, 1, 0, 6'h30, 0};
    tbl[5]  = '{0, 0, 0, 0, 16'h0000, 1, 0, 6'h30, 0};
    tbl[6]  = '{0, 0, 0, 0, 16'h0000, 1, 0, 6'h30, 0};
    tbl[7]  = '{0, 0, 0, 0, 16'h0000, 1, 1, 6'h30, 0};
    tbl[8]  = '{0, 0, 0, 0, 16'h0000, 1, 1, 6'h0C, 0};
    tbl[9]  = '{0, 1, 0, 0, 16'h0000, 1, 1, 6'h00, 0};
    tbl[10] = '{0, 0, 0, 0, 16'h0000, 1, 1, 6'h00, 1};
    tbl[11] = '{0, 1, 1, 1, 16'h0021, 1, 0, 6'h00, 0};
    tbl[12] = '{0, 1, 0, 1, 16'h0021, 1, 1, 6'h00, 0};

    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].r, tbl[i].b, tbl[i].n, tbl[i].v, tbl[i].d);
      if (tbl[i].ck_rdy)
        chk($sformatf("tbl%0d_ready", i), {31'd0, rdy_s},
            {31'd0, tbl[i].rdy});
      chk($sformatf("tbl%0d_rgb", i), {26'd0, rgb},
          {26'd0, tbl[i].rgb});
      chk($sformatf("tbl%0d_uf", i), {31'd0, underflow},
          {31'd0, tbl[i].uf});
    end

    // back-to-back 1-pixel runs, colours 1..8
    cyc(1, 1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, i < 3, 0, 1, tok(0, 6'(i)));
      chk("b2b_ready", {31'd0, rdy_s}, 32'd1);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);

    // blank span in the middle of a 10-pixel run
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, tok(9, 6'h3F));
    cyc(0, 1, 0, 1, tok(0, 6'h11));
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, tok(0, 6'h11));
    for (int i = 0; i < 160; i++) cyc(0, 1, 0, 1, tok(0, 6'h11));
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, tok(0, 6'h22));

    // underflow, then normal display with sticky flag held
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, tok(1, 6'h05));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    chk("uf_sticky", {31'd0, underflow}, 32'd1);

    // frame pulse mid-run with a token pending
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 1, tok(100, 6'h15));
    cyc(0, 1, 0, 1, tok(2, 6'h2A));
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, tok(2, 6'h2A));
    cyc(0, 0, 1, 1, tok(3, 6'h33));
    chk("nf_ready", {31'd0, rdy_s}, 32'd0);
    cyc(0, 1, 0, 1, tok(1, 6'h07));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic r, b, n, v;
      int   len;
      r   = ($urandom_range(0, 499) == 0);
      n   = ($urandom_range(0, 199) == 0);
      b   = ($urandom_range(0, 99) < 30);
      v   = ($urandom_range(0, 99) < 75);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40)
                                        : $urandom_range(0, 3);
      cyc(r, b, n, v, tok(len, 6'($urandom)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
